// File: rtl/cone_sched_pkg.sv
// Shared types and widths for the cone evaluation scheduler.
package cone_sched_pkg;

   localparam int unsigned CONE_IN_W = 15;
   localparam int unsigned STAT_W    = 16;
   localparam logic [STAT_W-1:0] STAT_MAX = 16'hFFFF;

   typedef enum logic [1:0] {
      IDLE        = 2'd0,
      SETTLE_WAIT = 2'd1,
      RESP        = 2'd2
   } state_t;

endpackage

// File: rtl/cone_rr_arb.sv
// Round-robin arbiter: picks the first asserted request at or after ptr, with wrap.
// The pointer is owned by the caller so it only moves on a real transfer.
module cone_rr_arb #(
   parameter  int unsigned NREQ = 4,
   localparam int unsigned IDW  = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [IDW-1:0]  ptr,
   output logic [NREQ-1:0] gnt,
   output logic [IDW-1:0]  gnt_id
);

   logic        found;
   int unsigned idx;

   // Search ptr, ptr+1, ... (mod NREQ) and grant the first requester found.
   always_comb begin
      gnt    = '0;
      gnt_id = '0;
      found  = 1'b0;
      idx    = 0;
      for (int unsigned off = 0; off < NREQ; off++) begin
         idx = 32'(ptr) + off;
         if (idx >= NREQ) idx = idx - NREQ;
         if (!found && req[IDW'(idx)]) begin
            found              = 1'b1;
            gnt[IDW'(idx)]     = 1'b1;
            gnt_id             = IDW'(idx);
         end
      end
   end

endmodule

// File: rtl/cone_eval_sched.sv
// Round-robin scheduler sharing one combinational cone among NREQ requesters.
// Optional statistics counters are enabled with CONE_SCHED_STATS_EN.
module cone_eval_sched
   import cone_sched_pkg::*;
#(
   parameter  int unsigned NREQ   = 4,
   parameter  int unsigned SETTLE = 2,
   localparam int unsigned IDW    = $clog2(NREQ)
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [NREQ-1:0]           req_valid,
   input  logic [NREQ*CONE_IN_W-1:0] req_vec,
   output logic [NREQ-1:0]           req_ready,
   output logic [CONE_IN_W-1:0]      cone_in,
   input  logic                      cone_out,
   output logic                      rsp_valid,
   input  logic                      rsp_ready,
   output logic [IDW-1:0]            rsp_id,
   output logic                      rsp_data,
`ifdef CONE_SCHED_STATS_EN
   input  logic                      stat_clr,
   output logic [STAT_W-1:0]         stat_evals,
   output logic [STAT_W-1:0]         stat_ones,
`endif
   output logic                      busy
);

   localparam int unsigned CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

   state_t                state, state_nxt;
   logic [CNT_W-1:0]      cnt, cnt_nxt;
   logic [IDW-1:0]        ptr, ptr_nxt;
   logic [CONE_IN_W-1:0]  cone_in_nxt;
   logic [IDW-1:0]        rsp_id_nxt;
   logic                  rsp_data_nxt;
   logic                  rsp_valid_nxt;
   logic [NREQ-1:0]       gnt;
   logic [IDW-1:0]        gnt_id;
   logic [CONE_IN_W-1:0]  sel_vec;

   cone_rr_arb #(.NREQ(NREQ)) u_arb (
      .req    (req_valid),
      .ptr    (ptr),
      .gnt    (gnt),
      .gnt_id (gnt_id)
   );

   // Select the granted requester's vector.
   always_comb begin
      sel_vec = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         if (gnt[i]) sel_vec = req_vec[i*CONE_IN_W +: CONE_IN_W];
      end
   end

   // Next-state and datapath next values; grants only in IDLE and never during reset.
   always_comb begin
      state_nxt     = state;
      cnt_nxt       = cnt;
      ptr_nxt       = ptr;
      cone_in_nxt   = cone_in;
      rsp_id_nxt    = rsp_id;
      rsp_data_nxt  = rsp_data;
      rsp_valid_nxt = rsp_valid;
      req_ready     = '0;
      unique case (state)
         IDLE: begin
            req_ready = rst_n ? gnt : '0;
            if (|gnt) begin
               cone_in_nxt = sel_vec;
               rsp_id_nxt  = gnt_id;
               cnt_nxt     = CNT_W'(SETTLE - 1);
               ptr_nxt     = (gnt_id == IDW'(NREQ - 1)) ? '0 : gnt_id + IDW'(1);
               state_nxt   = SETTLE_WAIT;
            end
         end
         SETTLE_WAIT: begin
            if (cnt == '0) begin
               rsp_data_nxt  = cone_out;
               rsp_valid_nxt = 1'b1;
               state_nxt     = RESP;
            end else begin
               cnt_nxt = cnt - CNT_W'(1);
            end
         end
         RESP: begin
            if (rsp_ready) begin
               rsp_valid_nxt = 1'b0;
               state_nxt     = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // State and datapath registers; reset abandons any evaluation in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         cnt       <= '0;
         ptr       <= '0;
         cone_in   <= '0;
         rsp_id    <= '0;
         rsp_data  <= 1'b0;
         rsp_valid <= 1'b0;
         busy      <= 1'b0;
      end else begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         ptr       <= ptr_nxt;
         cone_in   <= cone_in_nxt;
         rsp_id    <= rsp_id_nxt;
         rsp_data  <= rsp_data_nxt;
         rsp_valid <= rsp_valid_nxt;
         busy      <= (state_nxt != IDLE);
      end
   end

`ifdef CONE_SCHED_STATS_EN
   logic rsp_hs;
   assign rsp_hs = rsp_valid & rsp_ready;

   // Saturating evaluation counters; a clear takes priority over a same-cycle handshake.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stat_evals <= '0;
         stat_ones  <= '0;
      end else if (stat_clr) begin
         stat_evals <= '0;
         stat_ones  <= '0;
      end else if (rsp_hs) begin
         if (stat_evals != STAT_MAX) stat_evals <= stat_evals + STAT_W'(1);
         if (rsp_data && (stat_ones != STAT_MAX)) stat_ones <= stat_ones + STAT_W'(1);
      end
   end
`endif

endmodule

// File: tb/tb_cone_eval_sched.sv
// Directed bench for cone_eval_sched (NREQ=4, SETTLE=2). Cone model: odd parity of cone_in,
// optionally inverted by cone_flip. Statistics checks compile when CONE_SCHED_STATS_EN is defined.
module tb_cone_eval_sched;

   localparam int unsigned NREQ   = 4;
   localparam int unsigned SETTLE = 2;

   logic             clk = 1'b0;
   logic             rst_n;
   logic [NREQ-1:0]  req_valid;
   logic [NREQ*15-1:0] req_vec;
   logic [NREQ-1:0]  req_ready;
   logic [14:0]      cone_in;
   logic             cone_out;
   logic             rsp_valid;
   logic             rsp_ready;
   logic [1:0]       rsp_id;
   logic             rsp_data;
   logic             busy;
   logic             cone_flip;
`ifdef CONE_SCHED_STATS_EN
   logic             stat_clr;
   logic [15:0]      stat_evals;
   logic [15:0]      stat_ones;
`endif

   int n_cmp = 0;
   int n_err = 0;

   assign cone_out = (^cone_in) ^ cone_flip;

   always #5 clk = ~clk;

   cone_eval_sched #(.NREQ(NREQ), .SETTLE(SETTLE)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_vec    (req_vec),
      .req_ready  (req_ready),
      .cone_in    (cone_in),
      .cone_out   (cone_out),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_id     (rsp_id),
      .rsp_data   (rsp_data),
`ifdef CONE_SCHED_STATS_EN
      .stat_clr   (stat_clr),
      .stat_evals (stat_evals),
      .stat_ones  (stat_ones),
`endif
      .busy       (busy)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic set_vec(input int i, input logic [14:0] v);
      req_vec[15*i +: 15] = v;
   endtask

   // Entered at a negedge in IDLE with requests already driven; rsp_ready assumed high.
   task automatic eval_check(input int id, input logic [14:0] vec, input logic dat, input logic drop);
      #1;
      chk("grant_onehot", 32'(req_ready), 32'(1) << id);
      @(negedge clk);
      chk("cone_in_at_grant", 32'(cone_in), 32'(vec));
      chk("busy_after_grant", 32'(busy), 32'd1);
      chk("ready_low_settle", 32'(req_ready), 32'd0);
      if (drop) req_valid = '0;
      @(negedge clk);
      chk("no_rsp_early", 32'(rsp_valid), 32'd0);
      @(negedge clk);
      chk("rsp_valid", 32'(rsp_valid), 32'd1);
      chk("rsp_id", 32'(rsp_id), 32'(id));
      chk("rsp_data", 32'(rsp_data), 32'(dat));
      @(negedge clk);
      chk("rsp_valid_drop", 32'(rsp_valid), 32'd0);
      chk("busy_idle", 32'(busy), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_n     = 1'b0;
      req_valid = 4'hF;
      req_vec   = '0;
      rsp_ready = 1'b1;
      cone_flip = 1'b0;
`ifdef CONE_SCHED_STATS_EN
      stat_clr  = 1'b0;
`endif
      set_vec(0, 15'h0001);
      set_vec(1, 15'h0003);
      set_vec(2, 15'h0007);
      set_vec(3, 15'h000F);

      // reset state, req_ready suppressed during reset
      @(negedge clk);
      @(negedge clk);
      chk("rst_cone_in", 32'(cone_in), 32'd0);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_rsp_id", 32'(rsp_id), 32'd0);
      chk("rst_rsp_data", 32'(rsp_data), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_req_ready", 32'(req_ready), 32'd0);
      req_valid = '0;
      rst_n     = 1'b1;
      @(negedge clk);
      chk("idle_no_req", 32'(req_ready), 32'd0);

      // all requesters valid: 0,1,2,3,0
      req_valid = 4'hF;
      eval_check(0, 15'h0001, 1'b1, 1'b0);
      eval_check(1, 15'h0003, 1'b0, 1'b0);
      eval_check(2, 15'h0007, 1'b1, 1'b0);
      eval_check(3, 15'h000F, 1'b0, 1'b0);
      eval_check(0, 15'h0001, 1'b1, 1'b1);

      // single request from 1, vec 0x1234 (odd parity -> 1); cone_in holds afterwards
      set_vec(1, 15'h1234);
      req_valid = 4'b0010;
      eval_check(1, 15'h1234, 1'b1, 1'b1);
      @(negedge clk);
      chk("cone_in_hold", 32'(cone_in), 32'h1234);

      // wrap: 3 alone, then 0 and 3 together -> 0 wins
      req_valid = 4'b1000;
      eval_check(3, 15'h000F, 1'b0, 1'b1);
      req_valid = 4'b1001;
      eval_check(0, 15'h0001, 1'b1, 1'b1);

      // backpressure: pointer at 1, reqs 2 and 3 -> 2 wins, held 10 cycles
      rsp_ready = 1'b0;
      req_valid = 4'b1100;
      #1;
      chk("bp_grant", 32'(req_ready), 32'b0100);
      @(negedge clk);
      chk("bp_cone_in", 32'(cone_in), 32'h0007);
      req_valid = 4'b1000;
      @(negedge clk);
      @(negedge clk);
      chk("bp_rsp_valid0", 32'(rsp_valid), 32'd1);
      cone_flip = 1'b1;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
         chk("bp_rsp_id", 32'(rsp_id), 32'd2);
         chk("bp_rsp_data", 32'(rsp_data), 32'd1);
         chk("bp_req_ready", 32'(req_ready), 32'd0);
         chk("bp_cone_in_hold", 32'(cone_in), 32'h0007);
      end
      cone_flip = 1'b0;
      rsp_ready = 1'b1;
      @(negedge clk);
      chk("bp_released", 32'(rsp_valid), 32'd0);
      #1;
      chk("bp_next_grant", 32'(req_ready), 32'b1000);
      req_valid = '0;

      // reset during SETTLE_WAIT: pointer at 3, only req 0
      @(negedge clk);
      req_valid = 4'b0001;
      #1;
      chk("mr_grant", 32'(req_ready), 32'b0001);
      @(negedge clk);
      chk("mr_cone_in", 32'(cone_in), 32'h0001);
      req_valid = '0;
      #2;
      rst_n = 1'b0;
      #1;
      chk("mr_cone_in_rst", 32'(cone_in), 32'd0);
      chk("mr_busy_rst", 32'(busy), 32'd0);
      chk("mr_rsp_valid_rst", 32'(rsp_valid), 32'd0);
      chk("mr_rsp_id_rst", 32'(rsp_id), 32'd0);
      chk("mr_rsp_data_rst", 32'(rsp_data), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk("mr_no_rsp", 32'(rsp_valid), 32'd0);
         chk("mr_idle", 32'(busy), 32'd0);
      end
      // pointer was reset to 0
      req_valid = 4'hF;
      eval_check(0, 15'h0001, 1'b1, 1'b1);

`ifdef CONE_SCHED_STATS_EN
      stat_clr = 1'b1;
      @(negedge clk);
      stat_clr = 1'b0;
      chk("st_clr_evals", 32'(stat_evals), 32'd0);
      chk("st_clr_ones", 32'(stat_ones), 32'd0);
      set_vec(2, 15'h0003);
      set_vec(3, 15'h0007);
      req_valid = 4'b0010;
      eval_check(1, 15'h1234, 1'b1, 1'b1);
      req_valid = 4'b0100;
      eval_check(2, 15'h0003, 1'b0, 1'b1);
      req_valid = 4'b1000;
      eval_check(3, 15'h0007, 1'b1, 1'b1);
      chk("st_evals3", 32'(stat_evals), 32'd3);
      chk("st_ones2", 32'(stat_ones), 32'd2);
      // clear coincident with the 4th handshake
      req_valid = 4'b0001;
      @(negedge clk);
      req_valid = '0;
      @(negedge clk);
      @(negedge clk);
      chk("st_rsp4", 32'(rsp_valid), 32'd1);
      stat_clr = 1'b1;
      @(negedge clk);
      stat_clr = 1'b0;
      chk("st_clr_hs_evals", 32'(stat_evals), 32'd0);
      chk("st_clr_hs_ones", 32'(stat_ones), 32'd0);
      // saturation
      force dut.stat_evals = 16'hFFFF;
      #1;
      release dut.stat_evals;
      @(negedge clk);
      chk("st_forced", 32'(stat_evals), 32'hFFFF);
      req_valid = 4'b0010;
      eval_check(1, 15'h1234, 1'b1, 1'b1);
      chk("st_sat_evals", 32'(stat_evals), 32'hFFFF);
      chk("st_sat_ones", 32'(stat_ones), 32'd1);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
